// File: rtl/uart_mem_loader.sv
// Serial IMEM loader: UART RX front end plus a frame parser that writes
// little-endian 32-bit words and holds the CPU in reset during a transfer.
module uart_mem_loader #(
  parameter int CLK_FREQ       = 12_000_000,
  parameter int BAUD           = 115_200,
  parameter int ADDR_WIDTH     = 9,
  parameter int TIMEOUT_CYCLES = 16 * (CLK_FREQ / BAUD) * 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_uart_rx,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_wdata,
  output logic                  o_cpu_rst,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [2:0]            o_dbg_state
);

  localparam int CPB   = CLK_FREQ / BAUD;
  localparam int CNT_W = $clog2(CPB + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0] CAP = 17'(1) << ADDR_WIDTH;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;

  // Receiver: one-cycle byte_valid_q / frame_err_q pulses mark byte completion.
  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_byte_q    <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_meta_q    <= i_uart_rx;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_byte_q    <= rx_byte_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q + CNT_W'(1);
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_byte_d    = rx_byte_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        // Re-check mid start bit; a short glitch returns here to idle.
        if (rx_cnt_q == CNT_W'(CPB / 2 - 1)) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == CNT_W'(CPB - 1)) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == CNT_W'(CPB - 1)) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          if (rx_sync_q) begin
            byte_valid_d = 1'b1;
            rx_byte_d    = rx_shift_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Frame parser
  state_t                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           words_q, words_d;
  logic [1:0]            bidx_q, bidx_d;
  logic [7:0]            sum_q, sum_d;
  logic [31:0]           word_q, word_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  active;
  logic [15:0]           len_full;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      words_q     <= '0;
      bidx_q      <= '0;
      sum_q       <= '0;
      word_q      <= '0;
      tmo_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      words_q     <= words_d;
      bidx_q      <= bidx_d;
      sum_q       <= sum_d;
      word_q      <= word_d;
      tmo_q       <= tmo_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign active   = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                    (state_q == S_DATA) || (state_q == S_CSUM);
  assign len_full = {rx_byte_q, len_q[7:0]};

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    words_d     = words_q;
    bidx_d      = bidx_q;
    sum_d       = sum_q;
    word_d      = word_q;
    tmo_d       = active ? tmo_q + TMO_W'(1) : '0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (byte_valid_q) tmo_d = '0;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (byte_valid_q && rx_byte_q == 8'hA5) begin
          state_d = S_LEN0;
          words_d = '0;
          bidx_d  = '0;
          sum_d   = '0;
        end
      end
      S_LEN0: if (byte_valid_q) begin
        len_d[7:0] = rx_byte_q;
        state_d    = S_LEN1;
      end
      S_LEN1: if (byte_valid_q) begin
        len_d = len_full;
        if ({1'b0, len_full} > CAP) state_d = S_ERR;
        else if (len_full == 16'd0)  state_d = S_CSUM;
        else                         state_d = S_DATA;
      end
      S_DATA: if (byte_valid_q) begin
        sum_d  = sum_q + rx_byte_q;
        word_d = {rx_byte_q, word_q[31:8]};
        bidx_d = bidx_q + 2'd1;
        if (bidx_q == 2'd3) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = words_q[ADDR_WIDTH-1:0];
          mem_wdata_d = word_d;
          words_d     = words_q + 16'd1;
          if (words_d == len_q) state_d = S_CSUM;
        end
      end
      S_CSUM: if (byte_valid_q) state_d = (rx_byte_q == sum_q) ? S_DONE : S_ERR;
      default: state_d = S_IDLE;
    endcase
    if (active && frame_err_q) state_d = S_ERR;
    if (active && !byte_valid_q && tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) state_d = S_ERR;
  end

  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_busy      = active;
  assign o_cpu_rst   = active;
  assign o_done      = (state_q == S_DONE);
  assign o_err       = (state_q == S_ERR);
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Randomized frame bench: expected IMEM writes go into a queue, a monitor
// pops and compares on every write strobe; frame status checked per frame.
module tb_uart_mem_loader;
  localparam int CPB = 10;
  localparam int AW  = 4;
  localparam int CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx  = 1'b1;
  logic          mem_we, cpu_rst, busy, done, err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [2:0]    dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [AW+31:0] exp_q[$];
  logic [31:0]    words[$];
  logic           prev_we = 1'b0;

  uart_mem_loader #(
    .CLK_FREQ(1_000_000), .BAUD(100_000), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16 * CPB * 10)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_uart_rx(rx),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_cpu_rst(cpu_rst), .o_busy(busy), .o_done(done), .o_err(err),
    .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Write monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      checks++;
      if (prev_we) begin
        failures++;
        $display("FAIL we_width actual=2+cycles expected=1");
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write actual=%0h:%0h expected=none", mem_addr, mem_wdata);
      end else begin
        logic [AW+31:0] e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          failures++;
          $display("FAIL write actual=%0h:%0h expected=%0h:%0h",
                   mem_addr, mem_wdata, e[AW+31:32], e[31:0]);
        end
      end
    end
    prev_we = mem_we;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_v = 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_v;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("idle_within_budget", busy, 0);
  endtask

  task automatic end_status(input string name, input bit exp_done);
    wait_idle(2000);
    check({name, "_done"}, done, exp_done);
    check({name, "_err"}, err, !exp_done);
    check({name, "_cpu_rst"}, cpu_rst, 0);
    check({name, "_pending_writes"}, exp_q.size(), 0);
  endtask

  task automatic send_sync();
    send_byte(8'hA5);
    check("cpu_rst_after_sync", cpu_rst, 1);
    check("busy_after_sync", busy, 1);
    check("status_cleared_on_sync", {done, err}, 0);
  endtask

  // Sends the words queued in 'words' as one frame; checksum is the byte sum.
  task automatic send_frame(input string name, input bit bad_csum);
    logic [7:0] sum = 8'h00;
    logic [15:0] n;
    n = 16'(words.size());
    send_sync();
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    for (int i = 0; i < words.size(); i++) begin
      exp_q.push_back({AW'(i), words[i]});
      for (int k = 0; k < 4; k++) begin
        logic [31:0] w;
        w = words[i] >> (8 * k);
        sum = sum + w[7:0];
        send_byte(w[7:0]);
      end
    end
    check({name, "_cpu_rst_before_csum"}, cpu_rst, 1);
    send_byte(bad_csum ? sum + 8'd1 : sum);
    end_status(name, !bad_csum);
    words.delete();
  endtask

  initial begin
    logic all_zero;
    repeat (5) @(negedge clk);
    rst = 1'b0;

    all_zero = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if ({mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, err} != 0) all_zero = 1'b0;
    end
    check("reset_idle_outputs_zero", all_zero, 1);

    words.push_back(32'h12345678);
    words.push_back(32'hDEADBEEF);
    send_frame("frame_a_good", 1'b0);
    words.push_back(32'h12345678);
    words.push_back(32'hDEADBEEF);
    send_frame("frame_a_bad_csum", 1'b1);

    // Garbage before sync, then a glitch inside the header
    send_byte(8'h00); check("busy_after_garbage_00", busy, 0);
    send_byte(8'hFF); check("busy_after_garbage_ff", busy, 0);
    send_byte(8'h3C); check("busy_after_garbage_3c", busy, 0);
    send_sync();
    rx = 1'b0; repeat (3) @(negedge clk); rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_state_len0", dbg_state, 3'd1);
    send_byte(8'h01); send_byte(8'h00);
    exp_q.push_back({AW'(0), 32'hCAFE0123});
    send_byte(8'h23); send_byte(8'h01); send_byte(8'hFE); send_byte(8'hCA);
    send_byte(8'h23 + 8'h01 + 8'hFE + 8'hCA);
    end_status("glitch_frame", 1'b1);

    // Length boundaries
    send_sync(); send_byte(8'h11); send_byte(8'h00);
    end_status("len_17", 1'b0);
    send_sync(); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    end_status("len_0", 1'b1);
    for (int i = 0; i < CAP; i++) words.push_back($urandom);
    send_frame("len_full", 1'b0);

    // Random frames
    for (int f = 0; f < 4; f++) begin
      int n;
      n = $urandom_range(CAP, 1);
      for (int i = 0; i < n; i++) words.push_back($urandom);
      send_frame("random_frame", $urandom_range(1, 0) == 1);
    end

    // Framing error on 2nd data byte
    send_sync(); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22, 1'b0);
    end_status("stop_bit_error", 1'b0);

    // Line idle after 3rd data byte
    send_sync(); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    check("busy_before_timeout", busy, 1);
    end_status("timeout", 1'b0);

    // Reset mid-DATA
    send_sync(); send_byte(8'h02); send_byte(8'h00);
    exp_q.push_back({AW'(0), 32'h44332211});
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66);
    check("reset_mid_first_word_written", exp_q.size(), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("reset_mid_outputs_zero",
          {mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, err}, 0);
    send_byte(8'h77); send_byte(8'h88);
    repeat (200) @(negedge clk);
    check("after_reset_outputs_zero",
          {mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, err}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
